ddr3_ring_scheduler: RTL and testbench
======================================

# ddr3_ring_scheduler

Burst scheduler that shares the MIG DDR3 user interface (app_*) between an ingress stream FIFO (256-bit read side of the capture FIFO) and an egress FIFO (256-bit write side of the host pipe-out FIFO). DDR3 is used as a circular buffer. Write bursts move ingress data into the ring. Read bursts move the oldest ring data out to egress. Grants alternate round-robin when both directions are eligible. The block sits between the stream FIFOs and the MIG instance and replaces the free-running write/read test sequencer.

## Interface
Parameters:
- ADDR_W, 30, MIG app_addr width.
- DATA_W, 256, app data width; one beat = one app command.
- ADDR_INC, 8, app_addr increment per beat (256 bit / 32-bit DQ).
- RING_BASE, 0, app_addr of the first ring beat.
- RING_BEATS, 4096, ring capacity in beats; must be a power of 2 and ≥ 2·BURST_LEN.
- BURST_LEN, 8, beats per granted burst.
- OB_DEPTH, 128, egress FIFO capacity in beats.
- OB_HEADROOM, 4, egress slack reserved for count latency.

Ports:
- clk in 1: MIG ui_clk; sole clock.
- rst_n in 1: asynchronous, active-low reset.
- enable in 1: level; scheduling permitted.
- calib_done in 1: MIG init_calib_complete.
- ib_re out 1: ingress read strobe.
- ib_data in DATA_W: ingress data, valid with ib_valid.
- ib_valid in 1: ingress data valid, one cycle after ib_re.
- ib_count in 7: ingress read-side occupancy.
- ob_we out 1: egress write strobe.
- ob_data out DATA_W: egress data.
- ob_count in 7: egress write-side occupancy.
- app_en, app_cmd[2:0], app_addr[ADDR_W-1:0] out: MIG command.
- app_rdy in 1: MIG command accept.
- app_wdf_wren, app_wdf_end out 1; app_wdf_data out DATA_W; app_wdf_mask out DATA_W/8: MIG write data.
- app_wdf_rdy in 1: MIG write data accept.
- app_rd_data in DATA_W; app_rd_data_valid in 1: MIG read return.
- fill out clog2(RING_BEATS)+1: beats stored in the ring and not yet read-issued.
- rd_pending out 5: read commands issued whose data has not yet returned.
- busy out 1: state ≠ IDLE or rd_pending ≠ 0.

## Operation
- States: IDLE, WR_FETCH, WR_WAIT, WR_ISSUE, RD_ISSUE.
- Write eligibility (we_ok): enable & calib_done & ib_count ≥ BURST_LEN & (RING_BEATS − fill) ≥ BURST_LEN.
- Read eligibility (re_ok): enable & calib_done & fill ≥ BURST_LEN & ob_count + rd_pending + BURST_LEN ≤ OB_DEPTH − OB_HEADROOM.
- Arbitration in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant the direction opposite to last_grant. last_grant resets to READ, so the first tie goes to WRITE.
  - Load beat_cnt = 0 on grant.
- Write path, per beat:
  - WR_FETCH: ib_re = 1 for one cycle, then go to WR_WAIT.
  - WR_WAIT: on ib_valid, latch ib_data into app_wdf_data, then go to WR_ISSUE.
  - WR_ISSUE: assert app_en (app_cmd = 3'b000, app_addr = wr_ptr) and app_wdf_wren with app_wdf_end = 1. Each signal is held until its own ready is sampled high. The two are tracked independently by cmd_done and dat_done.
  - When both are done: increment wr_ptr and beat_cnt. If beat_cnt = BURST_LEN−1, add BURST_LEN to fill and go to IDLE; otherwise go to WR_FETCH.
- Read path, RD_ISSUE:
  - Assert app_en with app_cmd = 3'b001, app_addr = rd_ptr.
  - On each app_rdy: increment rd_ptr, beat_cnt and rd_pending; decrement fill.
  - After BURST_LEN accepts, go to IDLE.
- Return path: ob_we <= app_rd_data_valid and ob_data <= app_rd_data (registered). rd_pending decrements on app_rd_data_valid. rd_pending increment and decrement in the same cycle net to zero.
- Pointers are beat indices modulo RING_BEATS. app_addr = RING_BASE + idx·ADDR_INC. Wrap from RING_BEATS−1 to 0.
- app_wdf_mask is constant 0.
- enable low mid-burst: the current burst completes, then the FSM stays in IDLE. Read returns keep draining.
- calib_done low: no new grants.
- Reset values: all outputs 0, state IDLE, fill/pointers/rd_pending 0. A reset mid-burst abandons the burst; the MIG is reset alongside.

## Timing
- IDLE → grant: 1 cycle after eligibility is registered.
- Write beat: 3 cycles minimum (FETCH, WAIT, ISSUE with both readys high). A write burst of 8 takes ≥ 24 cycles.
- Read burst: BURST_LEN cycles minimum at app_rdy = 1.
- Egress data: 1 cycle after app_rd_data_valid.
- Command signals never change while app_en = 1 & app_rdy = 0. Write data signals never change while app_wdf_wren = 1 & app_wdf_rdy = 0.
- fill is updated at write-burst completion only, so a read is never issued to a beat whose write command is not yet accepted.

## Structure
- Shared package ddr3_sched_pkg holds: the state enum, the MIG command constants (CMD_WR = 3'b000, CMD_RD = 3'b001), and the grant enum.
- One sub-module, ddr3_ring_ptr: a modulo-RING_BEATS pointer with increment and address generation, instantiated twice (wr, rd).

## Test plan
- ib_count = 8, ring empty, app_rdy = app_wdf_rdy = 1 → 8 write commands at addr 0, 8, …, 56; fill = 8 afterwards; then one read burst at addr 0…56 and fill = 0.
- app_rdy low for 5 cycles during WR_ISSUE while app_wdf_rdy = 1 → exactly one app_wdf_wren accept; app_en and app_addr stable until app_rdy rises.
- Both directions eligible repeatedly → grants alternate W, R, W, R starting with W.
- RING_BEATS = 16, sustained traffic → wr_ptr wraps from addr 120 to 0; fill never exceeds 16; no write is granted while fill > 8.
- ob_count = 118 with OB_DEPTH = 128 and OB_HEADROOM = 4 → no read grant; the read burst is granted once ob_count ≤ 116.
- rst_n asserted mid write burst → all outputs 0 immediately; fill = 0 and state IDLE after release.

Source files
------------

// File: rtl/ddr3_sched_pkg.sv
// Shared types and constants for the DDR3 ring scheduler.
//   state_e : scheduler FSM states
//   grant_e : direction of the most recent grant (round-robin memory)
//   CMD_WR / CMD_RD : MIG app_cmd encodings
package ddr3_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_FETCH,
    WR_WAIT,
    WR_ISSUE,
    RD_ISSUE
  } state_e;

  typedef enum logic {
    GNT_WRITE,
    GNT_READ
  } grant_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

endpackage

// File: rtl/ddr3_ring_ptr.sv
// Modulo-RING_BEATS beat pointer with MIG address generation.
//   clk, rst_n : clock, async active-low reset (pointer returns to beat 0)
//   inc        : advance one beat; wraps RING_BEATS-1 -> 0
//   addr       : RING_BASE + idx * ADDR_INC
module ddr3_ring_ptr #(
  parameter int ADDR_W     = 30,
  parameter int RING_BEATS = 4096,
  parameter int RING_BASE  = 0,
  parameter int ADDR_INC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  localparam int IW = $clog2(RING_BEATS);

  logic [IW-1:0] idx;

  // RING_BEATS is a power of two, so the natural binary rollover is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   idx <= '0;
    else if (inc) idx <= idx + IW'(1);
  end

  assign addr = ADDR_W'(RING_BASE) + ADDR_W'(idx) * ADDR_W'(ADDR_INC);

endmodule

// File: rtl/ddr3_ring_scheduler.sv
// Burst scheduler sharing the MIG app_* interface between the ingress
// capture FIFO (writes into a DDR3 ring) and the egress pipe-out FIFO
// (reads of the oldest ring data). Grants alternate on ties.
//   clk, rst_n        : MIG ui_clk, async active-low reset
//   enable, calib_done: scheduling permitted / MIG calibrated
//   ib_*              : ingress read strobe, data (1 cycle after ib_re), occupancy
//   ob_*              : egress write strobe/data (registered), occupancy
//   app_*             : MIG command, write data and read return
//   fill              : beats in the ring not yet read-issued
//   rd_pending        : read commands accepted whose data has not returned
//   busy              : FSM active or reads outstanding
module ddr3_ring_scheduler
  import ddr3_sched_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 256,
  parameter int ADDR_INC    = 8,
  parameter int RING_BASE   = 0,
  parameter int RING_BEATS  = 4096,
  parameter int BURST_LEN   = 8,
  parameter int OB_DEPTH    = 128,
  parameter int OB_HEADROOM = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          calib_done,
  output logic                          ib_re,
  input  logic [DATA_W-1:0]             ib_data,
  input  logic                          ib_valid,
  input  logic [6:0]                    ib_count,
  output logic                          ob_we,
  output logic [DATA_W-1:0]             ob_data,
  input  logic [6:0]                    ob_count,
  output logic                          app_en,
  output logic [2:0]                    app_cmd,
  output logic [ADDR_W-1:0]             app_addr,
  input  logic                          app_rdy,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [DATA_W-1:0]             app_wdf_data,
  output logic [DATA_W/8-1:0]           app_wdf_mask,
  input  logic                          app_wdf_rdy,
  input  logic [DATA_W-1:0]             app_rd_data,
  input  logic                          app_rd_data_valid,
  output logic [$clog2(RING_BEATS):0]   fill,
  output logic [4:0]                    rd_pending,
  output logic                          busy
);

  localparam int FW = $clog2(RING_BEATS) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  state_e            state, state_nx;
  grant_e            last_grant;
  logic [BW-1:0]     beat_cnt;
  logic              cmd_done, dat_done;
  logic [FW-1:0]     fill_q;
  logic [4:0]        rd_pend_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  logic              we_ok, re_ok;
  logic [FW-1:0]     room;
  logic [9:0]        ob_need;
  logic              grant_wr, grant_rd;
  logic              cmd_acc, dat_acc, beat_done, last_beat;
  logic              wr_inc, rd_inc;

  // ---------------- eligibility ----------------
  assign room    = FW'(RING_BEATS) - fill_q;
  assign ob_need = 10'(ob_count) + 10'(rd_pend_q) + 10'(BURST_LEN);

  assign we_ok = enable & calib_done & (ib_count >= 7'(BURST_LEN)) &
                 (room >= FW'(BURST_LEN));
  // Outstanding reads count against egress space: their data lands later.
  assign re_ok = enable & calib_done & (fill_q >= FW'(BURST_LEN)) &
                 (ob_need <= 10'(OB_DEPTH - OB_HEADROOM));

  assign last_beat = (beat_cnt == BW'(BURST_LEN - 1));

  // ---------------- pointers ----------------
  ddr3_ring_ptr #(
    .ADDR_W(ADDR_W), .RING_BEATS(RING_BEATS), .RING_BASE(RING_BASE), .ADDR_INC(ADDR_INC)
  ) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .inc(wr_inc), .addr(wr_addr)
  );

  ddr3_ring_ptr #(
    .ADDR_W(ADDR_W), .RING_BEATS(RING_BEATS), .RING_BASE(RING_BASE), .ADDR_INC(ADDR_INC)
  ) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .inc(rd_inc), .addr(rd_addr)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    ib_re        = 1'b0;
    app_en       = 1'b0;
    app_cmd      = CMD_WR;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    cmd_acc      = 1'b0;
    dat_acc      = 1'b0;
    beat_done    = 1'b0;
    wr_inc       = 1'b0;
    rd_inc       = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, take the direction not served last.
        if (we_ok && (!re_ok || last_grant == GNT_READ)) begin
          grant_wr = 1'b1;
          state_nx = WR_FETCH;
        end else if (re_ok) begin
          grant_rd = 1'b1;
          state_nx = RD_ISSUE;
        end
      end
      WR_FETCH: begin
        ib_re    = 1'b1;
        state_nx = WR_WAIT;
      end
      WR_WAIT: begin
        if (ib_valid) state_nx = WR_ISSUE;
      end
      WR_ISSUE: begin
        // Command and data handshakes complete independently; each is
        // dropped as soon as its own ready is seen.
        app_en       = !cmd_done;
        app_addr     = cmd_done ? '0 : wr_addr;
        app_wdf_wren = !dat_done;
        cmd_acc      = app_en & app_rdy;
        dat_acc      = app_wdf_wren & app_wdf_rdy;
        beat_done    = (cmd_done | cmd_acc) & (dat_done | dat_acc);
        if (beat_done) begin
          wr_inc   = 1'b1;
          state_nx = last_beat ? IDLE : WR_FETCH;
        end
      end
      RD_ISSUE: begin
        app_en   = 1'b1;
        app_cmd  = CMD_RD;
        app_addr = rd_addr;
        if (app_rdy) begin
          rd_inc = 1'b1;
          if (last_beat) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_READ;
      beat_cnt   <= '0;
      cmd_done   <= 1'b0;
      dat_done   <= 1'b0;
      fill_q     <= '0;
      rd_pend_q  <= '0;
      wdata_q    <= '0;
      ob_we      <= 1'b0;
      ob_data    <= '0;
    end else begin
      if (grant_wr)      last_grant <= GNT_WRITE;
      else if (grant_rd) last_grant <= GNT_READ;

      if (grant_wr || grant_rd)  beat_cnt <= '0;
      else if (wr_inc || rd_inc) beat_cnt <= beat_cnt + BW'(1);

      if (state == WR_WAIT && ib_valid) wdata_q <= ib_data;

      if (beat_done) begin
        cmd_done <= 1'b0;
        dat_done <= 1'b0;
      end else begin
        if (cmd_acc) cmd_done <= 1'b1;
        if (dat_acc) dat_done <= 1'b1;
      end

      // Fill grows only when a whole write burst is accepted, so reads can
      // never target a beat whose write command is still pending.
      if (wr_inc && last_beat) fill_q <= fill_q + FW'(BURST_LEN);
      else if (rd_inc)         fill_q <= fill_q - FW'(1);

      case ({rd_inc, app_rd_data_valid})
        2'b10:   rd_pend_q <= rd_pend_q + 5'd1;
        2'b01:   rd_pend_q <= rd_pend_q - 5'd1;
        default: ;
      endcase

      ob_we   <= app_rd_data_valid;
      ob_data <= app_rd_data;
    end
  end

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = wdata_q;
  assign app_wdf_mask = '0;
  assign fill         = fill_q;
  assign rd_pending   = rd_pend_q;
  assign busy         = (state != IDLE) || (rd_pend_q != 5'd0);

endmodule

// File: tb/tb_ddr3_ring_scheduler.sv
// Directed bench for ddr3_ring_scheduler with a 16-beat ring, a simple
// ingress FIFO model and a fixed-latency MIG model.
module tb_ddr3_ring_scheduler;

  localparam int AW = 30;
  localparam int DW = 256;

  logic            clk = 1'b0, rst_n = 1'b0, enable = 1'b0, calib_done = 1'b0;
  logic            ib_re;
  logic [DW-1:0]   ib_data = '0;
  logic            ib_valid = 1'b0;
  logic [6:0]      ib_count = '0;
  logic            ob_we;
  logic [DW-1:0]   ob_data;
  logic [6:0]      ob_count = '0;
  logic            app_en;
  logic [2:0]      app_cmd;
  logic [AW-1:0]   app_addr;
  logic            app_rdy = 1'b1;
  logic            app_wdf_wren, app_wdf_end;
  logic [DW-1:0]   app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask;
  logic            app_wdf_rdy = 1'b1;
  logic [DW-1:0]   app_rd_data;
  logic            app_rd_data_valid;
  logic [4:0]      fill;
  logic [4:0]      rd_pending;
  logic            busy;

  int checks = 0, failures = 0;

  ddr3_ring_scheduler #(.RING_BEATS(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .calib_done(calib_done),
    .ib_re(ib_re), .ib_data(ib_data), .ib_valid(ib_valid), .ib_count(ib_count),
    .ob_we(ob_we), .ob_data(ob_data), .ob_count(ob_count),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .fill(fill), .rd_pending(rd_pending), .busy(busy)
  );

  always #5 clk = ~clk;

  // Ingress FIFO: data one cycle after ib_re, values 1, 2, 3, ...
  int unsigned ib_seq = 0;
  always @(posedge clk) begin
    ib_valid <= ib_re;
    if (ib_re) begin
      ib_data <= DW'(ib_seq + 1);
      ib_seq  <= ib_seq + 1;
    end
  end

  // MIG: 16-entry memory, read data returns 4 cycles after command accept.
  logic [DW-1:0] mem [16];
  logic [3:0]    rv_sr = '0;
  logic [DW-1:0] rd_sr [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv_sr <= '0;
    else begin
      rv_sr    <= {rv_sr[2:0], app_en && app_rdy && app_cmd == 3'b001};
      rd_sr[0] <= mem[app_addr[6:3]];
      for (int i = 1; i < 4; i++) rd_sr[i] <= rd_sr[i-1];
      if (app_en && app_rdy && app_cmd == 3'b000) mem[app_addr[6:3]] <= app_wdf_data;
    end
  end
  assign app_rd_data_valid = rv_sr[3];
  assign app_rd_data       = rd_sr[3];

  // Monitors
  int wc_n = 0, wd_n = 0, rc_n = 0, od_n = 0, gl_n = 0, stab_bad = 0, wgnt_bad = 0, fill_max = 0;
  logic [AW-1:0] wa [64];
  logic [AW-1:0] ra [64];
  logic [31:0]   od [64];
  logic          gl [64];
  logic          hold_c = 1'b0;
  logic [AW-1:0] hold_a = '0;
  logic [2:0]    hold_k = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (app_en && app_rdy) begin
        if (app_addr[5:0] == 6'd0 && gl_n < 64) begin
          gl[gl_n] = (app_cmd == 3'b001);
          gl_n++;
        end
        if (app_cmd == 3'b000) begin
          if (app_addr[5:0] == 6'd0 && fill > 5'd8) wgnt_bad++;
          wa[wc_n[5:0]] = app_addr;
          wc_n++;
        end else begin
          ra[rc_n[5:0]] = app_addr;
          rc_n++;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) wd_n++;
      if (ob_we) begin
        od[od_n[5:0]] = ob_data[31:0];
        od_n++;
      end
      if (hold_c && !(app_en && app_addr == hold_a && app_cmd == hold_k)) stab_bad++;
      hold_c = app_en && !app_rdy;
      hold_a = app_addr;
      hold_k = app_cmd;
    end else begin
      hold_c = 1'b0;
    end
  end

  always @(negedge clk) if (int'(fill) > fill_max) fill_max = int'(fill);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, bad, p, w0;
    bit exp4 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit exp5 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_ctl", {ib_re, ob_we, app_en, app_wdf_wren, app_wdf_end, busy}, 0);
    chk("rst_fill", fill, 0);
    chk("rst_pend", rd_pending, 0);
    chk("rst_addr", app_addr, 0);
    chk("rst_mask", app_wdf_mask[63:0], 0);
    rst_n = 1'b1;
    enable = 1'b1;

    // ---- no grants without calibration ----
    ib_count = 7'd8;
    repeat (10) @(negedge clk);
    chk("nocal_idle", {busy, wc_n[7:0]}, 0);
    calib_done = 1'b1;

    // ---- basic write burst then read burst ----
    n = 0;
    while (wc_n < 8 && n < 200) begin @(negedge clk); n++; end
    ib_count = 7'd0;
    chk("wr1_count", wc_n, 8);
    chk("wr1_fill", fill, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("wr1_addr%0d", i), wa[i], i * 8);
    n = 0;
    while ((rc_n < 8 || od_n < 8 || busy) && n < 200) begin @(negedge clk); n++; end
    chk("rd1_count", rc_n, 8);
    chk("rd1_fill", fill, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rd1_addr%0d", i), ra[i], i * 8);
    for (int i = 0; i < 8; i++) chk($sformatf("eg1_data%0d", i), od[i], i + 1);
    chk("rd1_idle", {busy, rd_pending}, 0);

    // ---- app_rdy stall during WR_ISSUE ----
    app_rdy  = 1'b0;
    ib_count = 7'd8;
    n = 0;
    while (!app_en && n < 100) begin @(negedge clk); n++; end
    ib_count = 7'd0;
    chk("stall_addr", app_addr, 64);
    d0 = wd_n;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(app_en && app_addr == 64 && app_cmd == 3'b000)) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("stall_wdf_once", wd_n - d0, 1);
    chk("stall_wren_low", app_wdf_wren, 0);
    app_rdy = 1'b1;
    n = 0;
    while ((rc_n < 16 || od_n < 16 || busy) && n < 300) begin @(negedge clk); n++; end
    chk("wr2_count", wc_n, 16);
    chk("rd2_last_addr", ra[15], 120);
    chk("eg2_last_data", od[15], 16);
    chk("rd2_fill", fill, 0);

    // ---- egress headroom, ring full, pointer wrap, tie after read ----
    p = gl_n;
    ob_count = 7'd118;
    ib_count = 7'd8;
    n = 0;
    while (wc_n < 32 && n < 300) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    chk("ob118_no_rd", rc_n, 16);
    chk("full_fill", fill, 16);
    chk("full_no_wr", wc_n, 32);
    chk("full_idle", busy, 0);
    chk("wrap_hi", wa[15], 120);
    chk("wrap_lo", wa[16], 0);
    ob_count = 7'd117;
    repeat (10) @(negedge clk);
    chk("ob117_no_rd", rc_n, 16);
    ob_count = 7'd116;
    n = 0;
    while (rc_n < 17 && n < 50) begin @(negedge clk); n++; end
    chk("ob116_rd", rc_n > 16, 1);
    ob_count = 7'd0;
    n = 0;
    while (rc_n < 40 && n < 600) begin @(negedge clk); n++; end
    ib_count = 7'd0;
    chk("ph4_rd_count", rc_n, 40);
    for (int i = 0; i < 7; i++) chk($sformatf("ph4_gnt%0d", i), gl[p+i], exp4[i]);
    n = 0;
    while ((fill != 0 || busy || od_n != rc_n) && n < 300) begin @(negedge clk); n++; end
    chk("ph4_drain", rc_n, 48);
    chk("fill_max", fill_max, 16);
    chk("wr_gnt_fill", wgnt_bad, 0);

    // ---- alternation W,R,W,R from empty ring ----
    p = gl_n;
    ib_count = 7'd8;
    n = 0;
    while (rc_n < 64 && n < 600) begin @(negedge clk); n++; end
    ib_count = 7'd0;
    for (int i = 0; i < 4; i++) chk($sformatf("ph5_gnt%0d", i), gl[p+i], exp5[i]);
    n = 0;
    while ((busy || od_n != rc_n) && n < 100) begin @(negedge clk); n++; end
    chk("cmd_stable", stab_bad, 0);

    // ---- reset in the middle of a write burst ----
    w0 = wc_n;
    ob_count = 7'd118;
    ib_count = 7'd8;
    n = 0;
    while (wc_n < w0 + 8 && n < 200) begin @(negedge clk); n++; end
    app_rdy = 1'b0;
    n = 0;
    while (!app_en && n < 100) begin @(negedge clk); n++; end
    chk("prerst_addr", app_addr, 64);
    chk("prerst_fill", fill, 8);
    rst_n = 1'b0;
    #1;
    chk("rst2_ctl", {ib_re, ob_we, app_en, app_wdf_wren, app_wdf_end, busy}, 0);
    chk("rst2_addr_cmd", {app_cmd, app_addr}, 0);
    chk("rst2_wdata", app_wdf_data[63:0], 0);
    chk("rst2_odata", ob_data[63:0], 0);
    chk("rst2_fill_pend", {fill, rd_pending}, 0);
    repeat (2) @(negedge clk);
    app_rdy  = 1'b1;
    ib_count = 7'd0;
    ob_count = 7'd0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {busy, ib_re, fill}, 0);
    ib_count = 7'd8;
    n = 0;
    while (!app_en && n < 100) begin @(negedge clk); n++; end
    chk("post_rst_addr", app_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
